// File: rtl/buttons_scanner.sv
// Push-button scanner for the display board: clocks the external PISO shift register,
// debounces each button, latches sticky change flags with an irq, and serves an Avalon-MM read port.
module buttons_scanner #(
   parameter int CLK_DIV        = 25,
   parameter int NBITS          = 16,
   parameter int DEBOUNCE_SCANS = 4,
   parameter bit ACTIVE_LOW     = 1'b1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             shiftreg_in,
   output logic             shiftreg_loadn,
   output logic             shiftreg_clk,
   input  logic             address,
   input  logic             read,
   output logic [31:0]      readdata,
   output logic [NBITS-1:0] buttons,
   output logic             irq
);

   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int IDX_W = (NBITS > 1) ? $clog2(NBITS) : 1;
   localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);

   typedef enum logic [2:0] {
      ST_LOAD,
      ST_SETTLE,
      ST_SAMPLE,
      ST_SHIFT,
      ST_UPDATE
   } state_t;

   state_t             state, state_next;
   logic [DIV_W-1:0]   div;
   logic               div_last;
   logic [IDX_W-1:0]   idx;
   logic [NBITS-1:0]   shift_buf;
   logic [NBITS-1:0]   flags;
   logic [CNT_W-1:0]   cnt      [NBITS];
   logic [CNT_W-1:0]   cnt_next [NBITS];
   logic [NBITS-1:0]   raw;
   logic [NBITS-1:0]   buttons_next;
   logic [NBITS-1:0]   flags_set;
   logic               rd_flags;

   assign div_last = (div == DIV_W'(CLK_DIV - 1));
   assign rd_flags = read && address;

   // NOTE: every always_comb output gets a default before any branch so no latch can be inferred.
   always_comb begin
      state_next = state;
      case (state)
         ST_LOAD:   if (div_last) state_next = ST_SETTLE;
         ST_SETTLE: if (div_last) state_next = ST_SAMPLE;
         ST_SAMPLE: if (div_last) state_next = ST_SHIFT;
         ST_SHIFT:  if (div_last) state_next = (idx == '0) ? ST_UPDATE : ST_SAMPLE;
         ST_UPDATE: state_next = ST_LOAD;
         default:   state_next = ST_LOAD;
      endcase
   end

   // Per-button debounce: a bit flips only after DEBOUNCE_SCANS consecutive disagreeing scans.
   always_comb begin
      raw          = shift_buf ^ {NBITS{ACTIVE_LOW}};
      buttons_next = buttons;
      flags_set    = '0;
      for (int i = 0; i < NBITS; i++) begin
         cnt_next[i] = cnt[i];
         if (raw[i] == buttons[i]) begin
            cnt_next[i] = '0;
         end else if (cnt[i] >= CNT_W'(DEBOUNCE_SCANS - 1)) begin
            buttons_next[i] = raw[i];
            cnt_next[i]     = '0;
            flags_set[i]    = 1'b1;
         end else begin
            cnt_next[i] = cnt[i] + 1'b1;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= ST_LOAD;
         div       <= '0;
         idx       <= IDX_W'(NBITS - 1);
         shift_buf <= '0;
      end else begin
         state <= state_next;
         if (div_last || state == ST_UPDATE) div <= '0;
         else                                div <= div + 1'b1;
         if (state == ST_SAMPLE && div_last) shift_buf[idx] <= shiftreg_in;
         if (state == ST_SHIFT && div_last && idx != '0) idx <= idx - 1'b1;
         else if (state == ST_UPDATE)                    idx <= IDX_W'(NBITS - 1);
      end
   end

   // Pins come straight from flops, one cycle behind the state they represent.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         shiftreg_loadn <= 1'b1;
         shiftreg_clk   <= 1'b0;
      end else begin
         shiftreg_loadn <= (state != ST_LOAD);
         shiftreg_clk   <= (state == ST_SHIFT);
      end
   end

   // NOTE: the counter array is small and must start at zero, so it is reset like ordinary flops.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt     <= '{default: '0};
         buttons <= '0;
      end else if (state == ST_UPDATE) begin
         cnt     <= cnt_next;
         buttons <= buttons_next;
      end
   end

   // A flag raised on the same edge as a clearing read survives the clear.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         flags    <= '0;
         irq      <= 1'b0;
         readdata <= '0;
      end else begin
         flags <= (flags & ~{NBITS{rd_flags}}) | ((state == ST_UPDATE) ? flags_set : '0);
         irq   <= |flags;
         if (read) readdata <= address ? 32'(flags) : 32'(buttons);
      end
   end

endmodule

// File: tb/tb_buttons_scanner.sv
// Directed bench for buttons_scanner: a 16-bit PISO shift-register model feeds the
// scanner while scan timing, debounce, change flags, irq and the read port are checked.
module tb_buttons_scanner;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        shiftreg_in;
   logic        shiftreg_loadn;
   logic        shiftreg_clk;
   logic        address;
   logic        read;
   logic [31:0] readdata;
   logic [15:0] buttons;
   logic        irq;

   logic [15:0] model;
   logic [15:0] sr;
   int          cyc   = 0;
   int          nrise = 0;
   int          n_vec = 0;
   int          n_miss = 0;

   buttons_scanner dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .shiftreg_in    (shiftreg_in),
      .shiftreg_loadn (shiftreg_loadn),
      .shiftreg_clk   (shiftreg_clk),
      .address        (address),
      .read           (read),
      .readdata       (readdata),
      .buttons        (buttons),
      .irq            (irq)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge shiftreg_clk) nrise <= nrise + 1;

   // External shift register: parallel load on loadn falling, shift MSB-first on sclk rising.
   always @(negedge shiftreg_loadn or posedge shiftreg_clk) begin
      if (!shiftreg_loadn) sr <= model;
      else                 sr <= {sr[14:0], 1'b1};
   end
   assign shiftreg_in = sr[15];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Advance to just after the next falling edge of shiftreg_loadn, bounded.
   task automatic wait_fall();
      logic prev;
      bit   seen;
      int   waited;
      prev   = shiftreg_loadn;
      seen   = 1'b0;
      waited = 0;
      while (!seen && waited < 2000) begin
         step(1);
         waited++;
         seen = prev && !shiftreg_loadn;
         prev = shiftreg_loadn;
      end
      check("scan_start_seen", 32'(seen), 32'd1);
   endtask

   initial begin
      int t1, r1, low_cnt;

      reset_n = 1'b0;
      address = 1'b0;
      read    = 1'b0;
      model   = 16'hFFFF;
      step(3);
      check("rst_loadn", 32'(shiftreg_loadn), 32'd1);
      check("rst_sclk", 32'(shiftreg_clk), 32'd0);
      check("rst_buttons", 32'(buttons), 32'd0);
      check("rst_irq", 32'(irq), 32'd0);
      check("rst_readdata", readdata, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;

      // Idle board: scan timing and quiet outputs.
      wait_fall();
      t1 = cyc;
      r1 = nrise;
      low_cnt = 0;
      while (!shiftreg_loadn && low_cnt < 100) begin
         low_cnt++;
         step(1);
      end
      check("t1_loadn_low_cycles", 32'(low_cnt), 32'd25);
      wait_fall();
      check("t1_scan_period", 32'(cyc - t1), 32'd851);
      check("t1_sclk_rises", 32'(nrise - r1), 32'd16);
      check("t1_buttons", 32'(buttons), 32'd0);
      check("t1_irq", 32'(irq), 32'd0);

      // Buttons 15 and 0 pressed: four disagreeing scans before the flip.
      model = 16'h7FFE;
      repeat (4) wait_fall();
      check("t2_buttons_not_early", 32'(buttons), 32'd0);
      step(849);
      check("t2_buttons_before_upd4", 32'(buttons), 32'd0);
      step(1);
      check("t2_buttons_after_upd4", 32'(buttons), 32'h8001);
      check("t2_irq_same_cycle", 32'(irq), 32'd0);
      step(1);
      check("t2_irq_next_cycle", 32'(irq), 32'd1);

      // Bit 3 bounces every scan and must never be accepted.
      for (int i = 0; i < 10; i++) begin
         model = (i % 2 == 0) ? 16'h7FF6 : 16'h7FFE;
         wait_fall();
         check("t3_buttons_bounce", 32'(buttons), 32'h8001);
      end
      model = 16'h7FFE;
      wait_fall();

      // Read-to-clear flags, then read the button word.
      read = 1'b1; address = 1'b1;
      step(1);
      read = 1'b0;
      check("t4_read_flags", readdata, 32'h0000_8001);
      check("t4_irq_still_high", 32'(irq), 32'd1);
      step(1);
      check("t4_irq_dropped", 32'(irq), 32'd0);
      read = 1'b1; address = 1'b0;
      step(1);
      read = 1'b0;
      check("t4_read_buttons", readdata, 32'h0000_8001);
      step(3);
      check("t4_readdata_holds", readdata, 32'h0000_8001);

      // Release 15/0, then press 5 two scans later so its flip lands on a clearing read.
      wait_fall();
      model = 16'hFFFF;
      repeat (2) wait_fall();
      model = 16'hFFDF;
      repeat (3) wait_fall();
      check("t5_buttons_released", 32'(buttons), 32'd0);
      check("t5_irq_from_release", 32'(irq), 32'd1);
      wait_fall();
      step(849);
      read = 1'b1; address = 1'b1;
      step(1);
      read = 1'b0;
      check("t5_read_old_flags", readdata, 32'h0000_8001);
      check("t5_buttons_bit5", 32'(buttons), 32'h0020);
      step(1);
      check("t5_irq_stays_high", 32'(irq), 32'd1);
      read = 1'b1; address = 1'b1;
      step(1);
      read = 1'b0;
      check("t5_flag5_kept", readdata, 32'h0000_0020);
      step(1);
      check("t5_irq_cleared", 32'(irq), 32'd0);

      // Asynchronous reset in the middle of a SHIFT phase.
      wait_fall();
      step(80);
      check("t6_sclk_high_mid_shift", 32'(shiftreg_clk), 32'd1);
      #2;
      reset_n = 1'b0;
      #1;
      check("t6_async_loadn", 32'(shiftreg_loadn), 32'd1);
      check("t6_async_sclk", 32'(shiftreg_clk), 32'd0);
      check("t6_async_buttons", 32'(buttons), 32'd0);
      check("t6_async_irq", 32'(irq), 32'd0);
      check("t6_async_readdata", readdata, 32'd0);
      model = 16'hFFFF;
      step(2);
      @(negedge clk);
      reset_n = 1'b1;
      t1 = cyc;
      wait_fall();
      check("t6_first_load_latency", 32'(cyc - t1), 32'd1);
      t1 = cyc;
      r1 = nrise;
      wait_fall();
      check("t6_fresh_scan_period", 32'(cyc - t1), 32'd851);
      check("t6_fresh_sclk_rises", 32'(nrise - r1), 32'd16);
      check("t6_buttons_after", 32'(buttons), 32'd0);
      read = 1'b1; address = 1'b1;
      step(1);
      read = 1'b0;
      check("t6_flags_after_reset", readdata, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
